// File: rtl/mux8_to_1_pkg.sv
// Shared constants for the 8:1 mux family (package mux_pkg).
package mux_pkg;
  localparam int MUX8_NUM_IN = 8;
  localparam int MUX8_SEL_W  = 3;
endpackage

// File: rtl/mux8_to_1_mux2.sv
// 1-bit 2:1 mux leaf: y = sel ? b : a.
module mux2_to_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux8_to_1.sv
// WIDTH-bit 8:1 mux built as a 3-level tree of mux2_to_1 per bit.
// Optional output register enabled by defining MUX8_TO_1_OUT_REG_EN.
module mux8_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [MUX8_NUM_IN-1:0][WIDTH-1:0]    w,
  input  logic [MUX8_SEL_W-1:0]                sel,
  output logic [WIDTH-1:0]                     out
);

  logic [WIDTH-1:0] tree;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [3:0] l0;
    logic [1:0] l1;

    // Level 0 pairs (0,1)(2,3)(4,5)(6,7) on sel[0]
    for (genvar p = 0; p < 4; p++) begin : g_l0
      mux2_to_1 u_m (
        .a  (w[2*p][b]),
        .b  (w[2*p+1][b]),
        .sel(sel[0]),
        .y  (l0[p])
      );
    end

    for (genvar p = 0; p < 2; p++) begin : g_l1
      mux2_to_1 u_m (
        .a  (l0[2*p]),
        .b  (l0[2*p+1]),
        .sel(sel[1]),
        .y  (l1[p])
      );
    end

    mux2_to_1 u_l2 (
      .a  (l1[0]),
      .b  (l1[1]),
      .sel(sel[2]),
      .y  (tree[b])
    );
  end

`ifdef MUX8_TO_1_OUT_REG_EN
  logic [WIDTH-1:0] out_q, out_d;

  assign out_d = reset ? '0 : tree;

  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign out = out_q;
`else
  // Clock and reset are part of the fixed interface but idle here
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign out = tree;
`endif

endmodule

// File: tb/tb_mux8_to_1.sv
// Scoreboard bench for mux8_to_1: WIDTH=1 and WIDTH=64 instances.
// Expected latency follows MUX8_TO_1_OUT_REG_EN.
module tb_mux8_to_1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0][0:0]   w1;
  logic [2:0]        sel1;
  logic [0:0]        out1;
  logic [7:0][63:0]  w64;
  logic [2:0]        sel64;
  logic [63:0]       out64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] exp;
    bit          narrow;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  event ev_issue;

  always #5 clk = ~clk;

  mux8_to_1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .w(w1), .sel(sel1), .out(out1)
  );

  mux8_to_1 #(.WIDTH(64)) u_w64 (
    .clk(clk), .reset(reset), .w(w64), .sel(sel64), .out(out64)
  );

  // Monitor: waits for the output to become valid for the issued vector
  initial begin
    forever begin
      @(ev_issue);
`ifdef MUX8_TO_1_OUT_REG_EN
      @(posedge clk);
`endif
      #1;
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [63:0] act;
        e = exp_q.pop_front();
        n_checks++;
        if (e.narrow) begin
          act = {63'b0, out1[0]};
          if (act[0] !== e.exp[0]) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, act[0], e.exp[0]);
          end
        end else begin
          act = out64;
          if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  task automatic issue(input logic [63:0] e, input bit narrow, input string nm);
    exp_t x;
    x.exp = e;
    x.narrow = narrow;
    x.name = nm;
    exp_q.push_back(x);
    -> ev_issue;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t1_exp;
    w1 = '0; sel1 = '0; w64 = '0; sel64 = '0;
    @(negedge clk);

`ifdef MUX8_TO_1_OUT_REG_EN
    // Register build: reset clears, one-cycle latency, mid-stream reset
    w64 = '1; sel64 = 3'd2; reset = 1'b1;
    issue(64'h0, 1'b0, "reset_clears");
    reset = 1'b0;
    for (int k = 0; k < 8; k++) w64[k] = 64'(k);
    sel64 = 3'd6;
    issue(64'd6, 1'b0, "first_load_sel6");
    sel64 = 3'd3;
    issue(64'd3, 1'b0, "load_sel3");
    reset = 1'b1;
    issue(64'h0, 1'b0, "midstream_reset");
    reset = 1'b0;
    sel64 = 3'd7;
    issue(64'd7, 1'b0, "after_reset_sel7");
`else
    // Combinational build: reset must not disturb the output
    for (int k = 0; k < 8; k++) w64[k] = 64'(k);
    sel64 = 3'd6; reset = 1'b1;
    issue(64'd6, 1'b0, "reset_no_effect");
    reset = 1'b0;
`endif

    // 1. alternating pattern, WIDTH=1
    w1 = 8'b1010_1010;
    t1_exp = 8'b1010_1010;
    for (int s = 0; s < 8; s++) begin
      sel1 = 3'(s);
      issue({63'b0, t1_exp[s]}, 1'b1, $sformatf("alt_sel%0d", s));
    end

    // 2. walking one, all 64 sel/position combinations
    for (int k = 0; k < 8; k++) begin
      w1 = 8'(1 << k);
      for (int s = 0; s < 8; s++) begin
        sel1 = 3'(s);
        issue((s == k) ? 64'd1 : 64'd0, 1'b1, $sformatf("walk_k%0d_s%0d", k, s));
      end
    end

    // 3. w[k]=k, sweep sel, then back to 0
    for (int k = 0; k < 8; k++) w64[k] = 64'(k);
    for (int s = 0; s < 8; s++) begin
      sel64 = 3'(s);
      issue(64'(s), 1'b0, $sformatf("index_sel%0d", s));
    end
    sel64 = 3'd0;
    issue(64'd0, 1'b0, "index_back0");

    // 4. sel=5 fixed, only w[5] reaches the output
    sel64 = 3'd5;
    w64 = {8{64'hFFFF_0000_AAAA_5555}};
    w64[5] = 64'h0;
    issue(64'h0, 1'b0, "track_w5_zero");
    w64 = {8{64'h1357_9BDF_2468_ACE0}};
    w64[5] = 64'hDEAD_BEEF_0123_4567;
    issue(64'hDEAD_BEEF_0123_4567, 1'b0, "track_w5_dead");
    w64[4] = 64'h0; w64[6] = 64'h0;
    issue(64'hDEAD_BEEF_0123_4567, 1'b0, "track_w5_neighbors");

    // 5. unknown select: neighbours differ on every bit so X cannot merge away
    for (int k = 0; k < 8; k++) w64[k] = (k % 2 == 1) ? '1 : '0;
    sel64 = 3'bxxx;
    if ($isunknown(sel64)) issue({64{1'bx}}, 1'b0, "sel_x");
    else                   issue(w64[sel64], 1'b0, "sel_x_2state");
    sel64 = 3'd1;
    issue('1, 1'b0, "sel_recover");

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
